// File: rtl/uart_loader_gen2.sv
// UART boot loader: framed address/size/payload rounds into instr/data memories, binary ACK per round.
// Optional checksum byte per round when LOADER_CHECKSUM_EN is defined.
module uart_loader_gen2 #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] DATA_BASE = 32'h0000_0400,
    parameter int unsigned TIMEOUT   = 1_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic              tx_busy_i,
    output logic              tx_valid_o,
    output logic [7:0]        tx_data_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    output logic [DATA_W-1:0] instr_wdata_o,
    output logic              instr_we_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    output logic              data_we_o,
    output logic              core_reset_o,
    output logic              error_o
);
    localparam int unsigned BPW    = DATA_W / 8;
    localparam int unsigned LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [3:0] {
        RX_ADDR, RX_SIZE, ACK_SIZE, RX_DATA,
`ifdef LOADER_CHECKSUM_EN
        RX_CSUM,
`endif
        ACK_DONE, WAIT_TX, FINISH, ERR_TX
    } state_e;

`ifdef LOADER_CHECKSUM_EN
    localparam state_e PAY_END = RX_CSUM;
`else
    localparam state_e PAY_END = ACK_DONE;
`endif

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       shift_q, shift_d, size_q, size_d, rem_q, rem_d, idle_q, idle_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              tx_valid_q, tx_valid_d, instr_we_q, instr_we_d, data_we_q, data_we_d;
    logic              core_reset_q, core_reset_d, error_q, error_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [ADDR_W-1:0] instr_addr_q, instr_addr_d, data_addr_q, data_addr_d;
    logic [DATA_W-1:0] instr_wdata_q, instr_wdata_d, data_wdata_q, data_wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              ok_q, ok_d;
`endif

    logic [31:0]       shift_nxt;
    logic [DATA_W-1:0] word_nxt;
    logic              tx_send, tx_done, counting, timeout_hit;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        size_d        = size_q;
        rem_d         = rem_q;
        idle_d        = '0;
        waddr_d       = waddr_q;
        lane_d        = lane_q;
        word_d        = word_q;
        tx_valid_d    = 1'b0;
        tx_data_d     = tx_data_q;
        instr_we_d    = 1'b0;
        data_we_d     = 1'b0;
        instr_addr_d  = instr_addr_q;
        instr_wdata_d = instr_wdata_q;
        data_addr_d   = data_addr_q;
        data_wdata_d  = data_wdata_q;
        core_reset_d  = core_reset_q;
        error_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d         = sum_q;
        ok_d          = ok_q;
`endif
        shift_nxt = {shift_q[23:0], rx_data_i};
        word_nxt  = word_q | (DATA_W'(rx_data_i) << {lane_q, 3'b000});
        // Strobe only after a quiet cycle with tx idle; accepted if tx still idle during the strobe
        tx_send   = !tx_valid_q && !tx_busy_i;
        tx_done   = tx_valid_q && !tx_busy_i;
        counting  = (state_q == RX_SIZE) || (state_q == RX_DATA) ||
`ifdef LOADER_CHECKSUM_EN
                    (state_q == RX_CSUM) ||
`endif
                    ((state_q == RX_ADDR) && (cnt_q != 2'd0));
        if (counting && !rx_valid_i) idle_d = idle_q + 32'd1;
        timeout_hit = (TIMEOUT != 0) && counting && !rx_valid_i && (idle_q == 32'(TIMEOUT - 1));

        case (state_q)
            RX_ADDR: if (rx_valid_i) begin
                shift_d = shift_nxt;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd0) core_reset_d = 1'b1;
                if (cnt_q == 2'd3) begin
                    if (shift_nxt == 32'hFFFF_FFFF) begin
                        state_d = WAIT_TX;
                    end else begin
                        waddr_d = ADDR_W'(shift_nxt);
                        state_d = RX_SIZE;
                    end
                end
            end
            RX_SIZE: if (rx_valid_i) begin
                shift_d = shift_nxt;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    size_d  = shift_nxt;
                    rem_d   = shift_nxt;
                    lane_d  = '0;
                    word_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                    state_d = ACK_SIZE;
                end
            end
            ACK_SIZE: begin
                if (tx_send) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = size_q[{~cnt_q, 3'b111} -: 8];
                end
                if (tx_done) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = (rem_q == 32'd0) ? PAY_END : RX_DATA;
                end
            end
            RX_DATA: if (rx_valid_i) begin
                rem_d = rem_q - 32'd1;
`ifdef LOADER_CHECKSUM_EN
                sum_d = sum_q + rx_data_i;
`endif
                // Flush on a full word or on the last payload byte
                if ((lane_q == LANE_W'(BPW - 1)) || (rem_q == 32'd1)) begin
                    if (waddr_q >= ADDR_W'(DATA_BASE)) begin
                        data_we_d    = 1'b1;
                        data_addr_d  = waddr_q;
                        data_wdata_d = word_nxt;
                    end else begin
                        instr_we_d    = 1'b1;
                        instr_addr_d  = waddr_q;
                        instr_wdata_d = word_nxt;
                    end
                    word_d  = '0;
                    lane_d  = '0;
                    waddr_d = waddr_q + ADDR_W'(BPW);
                end else begin
                    word_d = word_nxt;
                    lane_d = lane_q + LANE_W'(1);
                end
                if (rem_q == 32'd1) state_d = PAY_END;
            end
`ifdef LOADER_CHECKSUM_EN
            RX_CSUM: if (rx_valid_i) begin
                ok_d    = (rx_data_i == sum_q);
                state_d = ACK_DONE;
            end
`endif
            ACK_DONE: begin
                if (tx_send) begin
                    tx_valid_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    tx_data_d  = ok_q ? 8'h06 : 8'h15;
`else
                    tx_data_d  = 8'h06;
`endif
                end
                if (tx_done) state_d = RX_ADDR;
            end
            WAIT_TX: if (!tx_busy_i) state_d = FINISH;
            FINISH: begin
                core_reset_d = 1'b0;
                state_d      = RX_ADDR;
            end
            ERR_TX: begin
                if (tx_send) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'hEE;
                end
                if (tx_done) state_d = RX_ADDR;
            end
            default: state_d = RX_ADDR;
        endcase

        if (timeout_hit) begin
            error_d = 1'b1;
            cnt_d   = 2'd0;
            idle_d  = '0;
            state_d = ERR_TX;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= RX_ADDR;
            cnt_q         <= '0;
            shift_q       <= '0;
            size_q        <= '0;
            rem_q         <= '0;
            idle_q        <= '0;
            waddr_q       <= '0;
            lane_q        <= '0;
            word_q        <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            instr_we_q    <= 1'b0;
            data_we_q     <= 1'b0;
            instr_addr_q  <= '0;
            instr_wdata_q <= '0;
            data_addr_q   <= '0;
            data_wdata_q  <= '0;
            core_reset_q  <= 1'b1;
            error_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q         <= '0;
            ok_q          <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            size_q        <= size_d;
            rem_q         <= rem_d;
            idle_q        <= idle_d;
            waddr_q       <= waddr_d;
            lane_q        <= lane_d;
            word_q        <= word_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            instr_we_q    <= instr_we_d;
            data_we_q     <= data_we_d;
            instr_addr_q  <= instr_addr_d;
            instr_wdata_q <= instr_wdata_d;
            data_addr_q   <= data_addr_d;
            data_wdata_q  <= data_wdata_d;
            core_reset_q  <= core_reset_d;
            error_q       <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q         <= sum_d;
            ok_q          <= ok_d;
`endif
        end
    end

    assign tx_valid_o    = tx_valid_q;
    assign tx_data_o     = tx_data_q;
    assign instr_addr_o  = instr_addr_q;
    assign instr_wdata_o = instr_wdata_q;
    assign instr_we_o    = instr_we_q;
    assign data_addr_o   = data_addr_q;
    assign data_wdata_o  = data_wdata_q;
    assign data_we_o     = data_we_q;
    assign core_reset_o  = core_reset_q;
    assign error_o       = error_q;
endmodule
